controle_comparador: RTL

Sequencing controller that compares two multi-nibble operands for equality by time-sharing a single 4-bit equality comparator (`sistema_y`, ports A, B, Q) across successive nibbles, LSB nibble first. It captures both operands on a start request, steps the shared comparator one nibble per clock, exits early on the first mismatch, and reports the result with a one-cycle done pulse. It sits between a requesting control unit and the existing combinational `sistema_y` datapath, and instantiates exactly one `sistema_y`.

---
 rtl/controle_comparador.sv | 138 +++++++++++++
 1 files changed

// File: rtl/controle_comparador.sv
// rtl/controle_comparador.sv - nibble-serial equality compare sequencer around one shared sistema_y

// 4-bit combinational equality comparator shared across all nibbles
module sistema_y (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       Q
);

    // Q is high when both nibbles are identical
    assign Q = (A == B);

endmodule

module controle_comparador #(
    parameter int NIBBLES = 4,
    parameter int IDXW    = $clog2(NIBBLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic                 equal,
    output logic [IDXW-1:0]      mismatch_idx
);

    localparam int              W        = 4 * NIBBLES;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic            equal_q, equal_d;
    logic [IDXW-1:0] mismatch_idx_q, mismatch_idx_d;

    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic            nib_eq;

    // Route nibble idx of both captured operands to the shared comparator
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = op_a_q[4*i +: 4];
                nib_b = op_b_q[4*i +: 4];
            end
        end
    end

    sistema_y u_sistema_y (
        .A (nib_a),
        .B (nib_b),
        .Q (nib_eq)
    );

    // Next-state and result update; abort outranks any compare outcome
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        equal_d        = equal_q;
        mismatch_idx_d = mismatch_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d         = op_a;
                    op_b_d         = op_b;
                    idx_d          = '0;
                    equal_d        = 1'b0;
                    mismatch_idx_d = '0;
                    state_d        = ST_CMP;
                end
            end
            ST_CMP: begin
                if (abort) begin
                    equal_d        = 1'b0;
                    mismatch_idx_d = '0;
                    state_d        = ST_IDLE;
                end else if (!nib_eq) begin
                    equal_d        = 1'b0;
                    mismatch_idx_d = idx_q;
                    state_d        = ST_DONE;
                end else if (idx_q == LAST_IDX) begin
                    equal_d        = 1'b1;
                    mismatch_idx_d = '0;
                    state_d        = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            equal_q        <= 1'b0;
            mismatch_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            equal_q        <= equal_d;
            mismatch_idx_q <= mismatch_idx_d;
        end
    end

    assign busy         = (state_q == ST_CMP);
    assign done         = (state_q == ST_DONE);
    assign equal        = equal_q;
    assign mismatch_idx = mismatch_idx_q;

endmodule
